inst_sram_bridge: RTL and testbench
===================================

// Module: inst_sram_bridge
// PURPOSE
//  Responder for the fetch-side instruction SRAM port. IF1 presents inst_sram_en/addr; IF2 samples the
//  64-bit inst_sram_rdata one cycle later and selects the 32-bit half with pc[2]. This block serves that
//  port from a one-line (8-byte) fetch buffer. On a miss it fills the line from a 32-bit external memory
//  using a req/ack handshake, two beats per line, and raises stallreq until the line is valid.
// PARAMETERS
//  ADDR_WD   32  byte-address width, fetch side and memory side
//  TAG_WD    ADDR_WD-3  line tag width (addr[ADDR_WD-1:3]); derived, do not override
// PORTS
//  clk             in   1        clock, rising edge
//  rst_n           in   1        asynchronous reset, active-low
//  flush           in   1        pipeline flush; drops the pending fetch request
//  inv             in   1        invalidate fetch buffer (fence.i)
//  inst_sram_en    in   1        fetch request valid
//  inst_sram_addr  in   ADDR_WD  fetch byte address; bits [2:0] ignored
//  inst_sram_rdata out  64       line of the request accepted in the previous cycle; {word@+4, word@+0}
//  stallreq        out  1        fetch stall request to the stall controller
//  mem_req         out  1        external read request
//  mem_addr        out  ADDR_WD  external word address, 4-byte aligned
//  mem_ack         in   1        external read complete; mem_rdata valid this cycle
//  mem_rdata       in   32       external read data
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - FSM=IDLE; buf_v=0; req_v_r=0; buf_data=0; mem_req=0; mem_addr=0; stallreq=0; inst_sram_rdata=0.
//   - Reset mid-fill abandons the transfer. The external side must tolerate a dropped request.
//  Request capture, at each posedge, in priority order:
//   1. flush: req_v_r<=0.
//   2. else if !stallreq: req_v_r<=inst_sram_en; req_tag_r<=inst_sram_addr[ADDR_WD-1:3].
//   3. else: hold.
//  Outputs:
//   - hit = buf_v & (buf_tag==req_tag_r).
//   - stallreq = req_v_r & !hit. This is combinational from registers only.
//   - inst_sram_rdata = buf_data at all times. It is stable while stallreq=1 and is valid whenever
//     req_v_r & hit.
//  FSM states:
//   - IDLE: if req_v_r & !hit & !flush: fill_tag<=req_tag_r, go RD_LO.
//   - RD_LO: mem_req=1, mem_addr={fill_tag,3'b000}. On mem_ack: lo<=mem_rdata, go RD_HI.
//   - RD_HI: mem_req=1, mem_addr={fill_tag,3'b100}. On mem_ack: buf_data<={mem_rdata,lo},
//     buf_tag<=fill_tag, buf_v<=!drop, drop<=0, go IDLE.
//   - While a fill is in flight, buf_v=0, so a stale line is never reported as hit.
//  Handshake: mem_req and mem_addr are held stable until mem_ack. A request is never withdrawn except
//  by reset. mem_ack outside RD_LO/RD_HI is ignored.
//  Timing, zero-wait memory (ack in the same cycle as req):
//   - miss seen in cycle M -> RD_LO in M+1 -> RD_HI in M+2 -> hit and stallreq=0 in M+3.
//   - Miss penalty is 3 cycles, plus wait states.
//  Boundary conditions:
//   - inv in IDLE: buf_v<=0 at the next edge.
//   - inv during RD_LO/RD_HI: drop<=1. The fill completes on the bus, the line is not validated, and a
//     still-pending request re-misses and refills.
//   - inv with RD_HI ack in the same cycle: line not validated.
//   - flush during fill: the fill completes and the line is validated (it is the correct memory image).
//     The new request is captured next cycle because stallreq=0 once req_v_r=0. If it misses, it waits
//     for IDLE and then starts its own fill.
//   - flush with miss in IDLE in the same cycle: no fill is started.
//   - Back-to-back requests in the same line: all hit, no external traffic.
//   - Address wrap: tag compare is full-width, so 0xFFFFFFF8 and 0x00000000 are distinct lines.
// TESTING
//  1. Cold fetch 0x1000 (mem_rdata 0x11111111 @0x1000, 0x22222222 @0x1004, zero-wait):
//     -> stallreq=1 for 3 cycles, mem_addr 0x1000 then 0x1004, then rdata=0x22222222_11111111, stallreq=0.
//  2. Then fetch 0x1004 and 0x1000 back-to-back -> stallreq=0, mem_req never asserted, rdata unchanged.
//  3. Miss at 0x2000 with mem_ack delayed 4 cycles per beat -> mem_req and mem_addr held stable,
//     stallreq=1 for 11 cycles.
//  4. inv asserted during RD_LO for a pending fetch 0x3000 -> first fill completes, a second fill to
//     0x3000 follows, then hit.
//  5. flush during RD_HI for 0x4000, new fetch 0x5000 -> 0x4000 line validated, then a 0x5000 fill starts
//     in the cycle after return to IDLE.
//  6. rst_n pulsed low while in RD_HI -> mem_req=0 and stallreq=0 immediately, buf_v=0, and the next
//     fetch misses.

Source files
------------

// File: rtl/inst_sram_bridge.sv
// Instruction SRAM responder backed by a single 8-byte fetch line.
// A miss fills the line from a 32-bit external memory in two req/ack beats
// (low word first) and holds stallreq until the line is valid.
//
// state | meaning
// IDLE  | no transfer; buffer valid or empty, waiting for a miss
// RD_LO | external read of the low word of fill_tag's line
// RD_HI | external read of the high word, then line update
module inst_sram_bridge #(
  parameter int ADDR_WD = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               inv,
  input  logic               inst_sram_en,
  input  logic [ADDR_WD-1:0] inst_sram_addr,
  output logic [63:0]        inst_sram_rdata,
  output logic               stallreq,
  output logic               mem_req,
  output logic [ADDR_WD-1:0] mem_addr,
  input  logic               mem_ack,
  input  logic [31:0]        mem_rdata
);

  localparam int TAG_WD = ADDR_WD - 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_LO = 2'd1,
    RD_HI = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic                req_v_r;
  logic [TAG_WD-1:0]   req_tag_r;
  logic                buf_v;
  logic [TAG_WD-1:0]   buf_tag;
  logic [63:0]         buf_data;
  logic [TAG_WD-1:0]   fill_tag;
  logic [31:0]         lo;
  logic                drop;
  logic                hit;
  logic                start_fill;

  // Byte offset within the line never selects anything here; IF2 uses pc[2].
  logic unused_addr_lsb;
  assign unused_addr_lsb = &{1'b0, inst_sram_addr[2:0]};

  assign hit             = buf_v & (buf_tag == req_tag_r);
  assign stallreq        = req_v_r & ~hit;
  assign inst_sram_rdata = buf_data;
  assign start_fill      = (state == IDLE) & req_v_r & ~hit & ~flush;

  // Capture the IF1 request; a stalled request is held until it hits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_v_r   <= 1'b0;
      req_tag_r <= '0;
    end else if (flush) begin
      req_v_r   <= 1'b0;
    end else if (!stallreq) begin
      req_v_r   <= inst_sram_en;
      req_tag_r <= inst_sram_addr[ADDR_WD-1:3];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: one beat per ack, low word then high word.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_fill) state_nxt = RD_LO;
      RD_LO:   if (mem_ack)    state_nxt = RD_HI;
      RD_HI:   if (mem_ack)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: request and address are pure functions of state, so they
  // stay stable until the ack moves the FSM on.
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = '0;
    case (state)
      RD_LO: begin
        mem_req  = 1'b1;
        mem_addr = {fill_tag, 3'b000};
      end
      RD_HI: begin
        mem_req  = 1'b1;
        mem_addr = {fill_tag, 3'b100};
      end
      default: begin
        mem_req  = 1'b0;
        mem_addr = '0;
      end
    endcase
  end

  // Line buffer and fill datapath; an invalidate seen at any point of a fill
  // (including the final ack cycle) keeps the refilled line invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_v    <= 1'b0;
      buf_tag  <= '0;
      buf_data <= '0;
      fill_tag <= '0;
      lo       <= '0;
      drop     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_fill) begin
            fill_tag <= req_tag_r;
            buf_v    <= 1'b0;
            drop     <= 1'b0;
          end else if (inv) begin
            buf_v    <= 1'b0;
          end
        end
        RD_LO: begin
          if (inv)     drop <= 1'b1;
          if (mem_ack) lo   <= mem_rdata;
        end
        RD_HI: begin
          if (mem_ack) begin
            buf_data <= {mem_rdata, lo};
            buf_tag  <= fill_tag;
            buf_v    <= ~(drop | inv);
            drop     <= 1'b0;
          end else if (inv) begin
            drop     <= 1'b1;
          end
        end
        default: begin
          drop <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_sram_bridge.sv
// Directed bench for inst_sram_bridge with a wait-state-configurable
// external memory responder.
module tb_inst_sram_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        inv;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [63:0] inst_sram_rdata;
  logic        stallreq;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  int          wait_states = 0;
  int          wcnt = 0;
  bit          pending = 1'b0;
  logic [31:0] last_addr = '0;
  int          req_cycles = 0;
  int          hold_err = 0;
  logic [31:0] ack_addr[$];

  inst_sram_bridge #(.ADDR_WD(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .inv             (inv),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_rdata (inst_sram_rdata),
    .stallreq        (stallreq),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_1000: mem_word = 32'h1111_1111;
      32'h0000_1004: mem_word = 32'h2222_2222;
      default:       mem_word = {16'hA5A5, a[15:0]};
    endcase
  endfunction

  // External memory: acks after wait_states idle request cycles, and flags
  // any address change or request withdrawal before the ack.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (!rst_n) begin
      pending = 1'b0;
      wcnt    = 0;
    end else if (mem_req) begin
      req_cycles++;
      if (pending && mem_addr !== last_addr) hold_err++;
      if (wcnt == wait_states) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(mem_addr);
        ack_addr.push_back(mem_addr);
        wcnt      = 0;
        pending   = 1'b0;
      end else begin
        wcnt++;
        pending   = 1'b1;
        last_addr = mem_addr;
      end
    end else begin
      if (pending) hold_err++;
      pending = 1'b0;
      wcnt    = 0;
    end
  end

  task automatic fetch(input string tag, input logic [31:0] a, input int exp_stall,
                       input logic [63:0] exp_data);
    int n;
    @(negedge clk);
    inst_sram_en   = 1'b1;
    inst_sram_addr = a;
    @(negedge clk);
    inst_sram_en = 1'b0;
    n = 0;
    while (stallreq && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_stall"}, 64'(n), 64'(exp_stall));
    check({tag, "_rdata"}, inst_sram_rdata, exp_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rc;
    rst_n = 1'b0; flush = 1'b0; inv = 1'b0;
    inst_sram_en = 1'b0; inst_sram_addr = '0;
    mem_ack = 1'b0; mem_rdata = '0;

    @(negedge clk);
    @(negedge clk);
    check("rst_stallreq", 64'(stallreq), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_rdata", inst_sram_rdata, 64'd0);
    #2 rst_n = 1'b1;

    // 1: cold fetch, zero-wait memory
    wait_states = 0;
    ack_addr.delete();
    fetch("t1", 32'h0000_1000, 3, 64'h2222_2222_1111_1111);
    check("t1_nacks", 64'(ack_addr.size()), 64'd2);
    check("t1_addr0", 64'(ack_addr[0]), 64'h1000);
    check("t1_addr1", 64'(ack_addr[1]), 64'h1004);

    // 2: back-to-back hits in the same line
    rc = req_cycles;
    @(negedge clk);
    inst_sram_en = 1'b1; inst_sram_addr = 32'h0000_1004;
    @(negedge clk);
    check("t2_stall_a", 64'(stallreq), 64'd0);
    check("t2_rdata_a", inst_sram_rdata, 64'h2222_2222_1111_1111);
    inst_sram_addr = 32'h0000_1000;
    @(negedge clk);
    check("t2_stall_b", 64'(stallreq), 64'd0);
    check("t2_rdata_b", inst_sram_rdata, 64'h2222_2222_1111_1111);
    inst_sram_en = 1'b0;
    @(negedge clk);
    check("t2_no_traffic", 64'(req_cycles - rc), 64'd0);

    // 3: four wait states per beat
    wait_states = 4;
    hold_err = 0;
    fetch("t3", 32'h0000_2000, 11, 64'hA5A5_2004_A5A5_2000);
    check("t3_hold", 64'(hold_err), 64'd0);

    // 4: invalidate during RD_LO forces a refill of the pending line
    wait_states = 1;
    ack_addr.delete();
    @(negedge clk);
    inst_sram_en = 1'b1; inst_sram_addr = 32'h0000_3000;
    @(negedge clk);
    inst_sram_en = 1'b0;
    @(negedge clk);
    check("t4_rdlo_addr", 64'(mem_addr), 64'h3000);
    inv = 1'b1;
    @(negedge clk);
    inv = 1'b0;
    n = 2;
    while (stallreq && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("t4_stall", 64'(n), 64'd10);
    check("t4_nacks", 64'(ack_addr.size()), 64'd4);
    check("t4_refill_addr", 64'(ack_addr[2]), 64'h3000);
    check("t4_rdata", inst_sram_rdata, 64'hA5A5_3004_A5A5_3000);

    // 5: flush during RD_HI, new fetch waits for IDLE then fills
    @(negedge clk);
    inst_sram_en = 1'b1; inst_sram_addr = 32'h0000_4000;
    @(negedge clk);
    inst_sram_en = 1'b0;
    check("t5_miss", 64'(stallreq), 64'd1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t5_rdhi_addr", 64'(mem_addr), 64'h4004);
    flush = 1'b1; inst_sram_en = 1'b1; inst_sram_addr = 32'h0000_5000;
    @(negedge clk);
    check("t5_flush_stall", 64'(stallreq), 64'd0);
    flush = 1'b0;
    @(negedge clk);
    inst_sram_en = 1'b0;
    check("t5_buf_v", 64'(dut.buf_v), 64'd1);
    check("t5_line4000", inst_sram_rdata, 64'hA5A5_4004_A5A5_4000);
    check("t5_new_miss", 64'(stallreq), 64'd1);
    check("t5_idle_req", 64'(mem_req), 64'd0);
    @(negedge clk);
    check("t5_fill_req", 64'(mem_req), 64'd1);
    check("t5_fill_addr", 64'(mem_addr), 64'h5000);
    n = 1;
    while (stallreq && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("t5_stall", 64'(n), 64'd5);
    check("t5_rdata", inst_sram_rdata, 64'hA5A5_5004_A5A5_5000);

    // 6: reset while in RD_HI
    wait_states = 4;
    @(negedge clk);
    inst_sram_en = 1'b1; inst_sram_addr = 32'h0000_6000;
    @(negedge clk);
    inst_sram_en = 1'b0;
    repeat (6) @(negedge clk);
    check("t6_rdhi_req", 64'(mem_req), 64'd1);
    check("t6_rdhi_addr", 64'(mem_addr), 64'h6004);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_req", 64'(mem_req), 64'd0);
    check("t6_rst_stall", 64'(stallreq), 64'd0);
    check("t6_rst_buf_v", 64'(dut.buf_v), 64'd0);
    check("t6_rst_rdata", inst_sram_rdata, 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_states = 0;
    fetch("t6_after", 32'h0000_1000, 3, 64'h2222_2222_1111_1111);

    // 7: address wrap, distinct lines at the top and bottom of memory
    fetch("t7_top", 32'hFFFF_FFF8, 3, 64'hA5A5_FFFC_A5A5_FFF8);
    fetch("t7_zero", 32'h0000_0000, 3, 64'hA5A5_0004_A5A5_0000);

    // 8: flush in the same cycle as a miss in IDLE starts no fill
    rc = req_cycles;
    @(negedge clk);
    inst_sram_en = 1'b1; inst_sram_addr = 32'h0000_7000;
    @(negedge clk);
    inst_sram_en = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("t8_stall", 64'(stallreq), 64'd0);
    @(negedge clk);
    check("t8_no_fill", 64'(req_cycles - rc), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
